// File: rtl/memory_stage.sv
// memory_stage: load/store stage between execute and writeback; optional bus timeout under `MEM_TIMEOUT_EN
// Control word layout: [0]=mem, [1]=iop (1=store), [4:2]=fcs_opcode, upper bits carried through untouched.
module memory_stage #(
    parameter int XLEN           = 32,
    parameter int CTL_W          = 16,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TIMEOUT_W      = 8
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_ex_done,
    input  logic [CTL_W-1:0] i_control_signal,
    input  logic [XLEN-1:0]  i_rd_output,
    input  logic [XLEN-1:0]  i_rs2,
    output logic             o_ready,
    output logic             o_mem_req,
    output logic             o_mem_we,
    output logic [XLEN-1:0]  o_mem_addr,
    output logic [XLEN-1:0]  o_mem_wdata,
    output logic [3:0]       o_mem_wstrb,
    input  logic             i_mem_ack,
    input  logic [XLEN-1:0]  i_mem_rdata,
    output logic             o_wb_valid,
    output logic [XLEN-1:0]  o_wb_data,
    output logic [CTL_W-1:0] o_control_signal,
    output logic             o_fault
);
    localparam int MEM_BIT = 0;
    localparam int IOP_BIT = 1;
    localparam int FCS_LSB = 2;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUS  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    if (XLEN != 32) begin : g_xlen_chk
        $error("memory_stage: byte-lane logic assumes a 32-bit bus");
    end
    if (TIMEOUT_W < $clog2(TIMEOUT_CYCLES + 1)) begin : g_tmo_chk
        $error("memory_stage: TIMEOUT_W too narrow for TIMEOUT_CYCLES");
    end

    logic [1:0]       state;
    logic [CTL_W-1:0] ctl_q;
    logic [1:0]       lane_q;
    logic [2:0]       in_fcs;
    logic             in_mem;
    logic             in_store;
    logic             bad_width;
    logic             misaligned;
    logic             dec_fault;
    logic [XLEN-1:0]  st_wdata;
    logic [3:0]       st_wstrb;
    logic [2:0]       ld_fcs;
    logic [7:0]       ld_byte;
    logic [15:0]      ld_half;
    logic [XLEN-1:0]  ld_data;
    logic             tmo_hit;

    assign o_ready          = state == IDLE;
    assign o_mem_req        = state == BUS;
    assign o_wb_valid       = state == DONE;
    assign o_control_signal = ctl_q;

    // Decode the incoming op: width legality, alignment and store lane placement
    always_comb begin
        in_fcs     = i_control_signal[FCS_LSB +: 3];
        in_mem     = i_control_signal[MEM_BIT];
        in_store   = i_control_signal[IOP_BIT];
        bad_width  = in_store ? (in_fcs[2] || in_fcs == 3'b011)
                              : (in_fcs == 3'b011 || in_fcs[2:1] == 2'b11);
        misaligned = (in_fcs[1:0] == 2'b01 && i_rd_output[0])
                  || (in_fcs[1:0] == 2'b10 && i_rd_output[1:0] != 2'b00);
        dec_fault  = bad_width || misaligned;
        st_wdata   = in_fcs[1:0] == 2'b00 ? {4{i_rs2[7:0]}}
                   : in_fcs[1:0] == 2'b01 ? {2{i_rs2[15:0]}} : i_rs2;
        st_wstrb   = !in_store            ? 4'b0000
                   : in_fcs[1:0] == 2'b00 ? 4'b0001 << i_rd_output[1:0]
                   : in_fcs[1:0] == 2'b01 ? 4'b0011 << {i_rd_output[1], 1'b0} : 4'b1111;
    end

    // Pick the addressed lane out of the returned word and extend it
    always_comb begin
        ld_fcs  = ctl_q[FCS_LSB +: 3];
        ld_byte = i_mem_rdata[{lane_q, 3'b000} +: 8];
        ld_half = i_mem_rdata[{lane_q[1], 4'b0000} +: 16];
        ld_data = ld_fcs[1:0] == 2'b00 ? {{(XLEN-8){ld_byte[7] & ~ld_fcs[2]}}, ld_byte}
                : ld_fcs[1:0] == 2'b01 ? {{(XLEN-16){ld_half[15] & ~ld_fcs[2]}}, ld_half}
                : i_mem_rdata;
    end

`ifdef MEM_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] tmo_cnt;

    assign tmo_hit = tmo_cnt == TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    // Count unacknowledged bus cycles; held at zero outside a transaction
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)
            tmo_cnt <= '0;
        else if (state != BUS)
            tmo_cnt <= '0;
        else if (!i_mem_ack && !tmo_hit)
            tmo_cnt <= tmo_cnt + 1'b1;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    // Sequencer: capture in IDLE, run the bus in BUS, present one writeback pulse in DONE
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state       <= IDLE;
            ctl_q       <= '0;
            lane_q      <= '0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            o_mem_wstrb <= '0;
            o_wb_data   <= '0;
            o_fault     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (i_ex_done) begin
                    ctl_q     <= i_control_signal;
                    lane_q    <= i_rd_output[1:0];
                    o_fault   <= in_mem && dec_fault;
                    o_wb_data <= in_mem ? '0 : i_rd_output;
                    if (in_mem && !dec_fault) begin
                        o_mem_we    <= in_store;
                        o_mem_addr  <= {i_rd_output[XLEN-1:2], 2'b00};
                        o_mem_wdata <= st_wdata;
                        o_mem_wstrb <= st_wstrb;
                        state       <= BUS;
                    end else begin
                        state <= DONE;
                    end
                end
                BUS: if (i_mem_ack || tmo_hit) begin
                    o_wb_data   <= (o_mem_we || !i_mem_ack) ? '0 : ld_data;
                    o_fault     <= !i_mem_ack;
                    o_mem_we    <= 1'b0;
                    o_mem_wstrb <= '0;
                    state       <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: directed checks of pass-through, loads, stores, faults, reset and throughput
module tb_memory_stage;
    logic        i_clk;
    logic        i_reset_n;
    logic        i_ex_done;
    logic [15:0] i_control_signal;
    logic [31:0] i_rd_output;
    logic [31:0] i_rs2;
    logic        o_ready;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_wstrb;
    logic        i_mem_ack;
    logic [31:0] i_mem_rdata;
    logic        o_wb_valid;
    logic [31:0] o_wb_data;
    logic [15:0] o_control_signal;
    logic        o_fault;
    int errors = 0;
    int checks = 0;

    memory_stage #(.XLEN(32), .CTL_W(16), .TIMEOUT_CYCLES(4), .TIMEOUT_W(8)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_ex_done(i_ex_done),
        .i_control_signal(i_control_signal), .i_rd_output(i_rd_output), .i_rs2(i_rs2),
        .o_ready(o_ready), .o_mem_req(o_mem_req), .o_mem_we(o_mem_we),
        .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_mem_wstrb(o_mem_wstrb),
        .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata), .o_wb_valid(o_wb_valid),
        .o_wb_data(o_wb_data), .o_control_signal(o_control_signal), .o_fault(o_fault)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // loads: fcs, addr, rdata, expected bus address, expected wb_data
    localparam logic [2:0]  LD_FCS [6] = '{3'b101, 3'b001, 3'b100, 3'b000, 3'b010, 3'b001};
    localparam logic [31:0] LD_ADR [6] = '{32'h2, 32'h2, 32'h101, 32'h101, 32'h4, 32'h0};
    localparam logic [31:0] LD_RD  [6] = '{32'h8001_0000, 32'h8001_0000, 32'h0000_9A00,
                                           32'h0000_9A00, 32'hDEAD_BEEF, 32'h1234_F00D};
    localparam logic [31:0] LD_BA  [6] = '{32'h0, 32'h0, 32'h100, 32'h100, 32'h4, 32'h0};
    localparam logic [31:0] LD_EXP [6] = '{32'h0000_8001, 32'hFFFF_8001, 32'h0000_009A,
                                           32'hFFFF_FF9A, 32'hDEAD_BEEF, 32'hFFFF_F00D};
    // stores: fcs, addr, rs2, expected bus address, wdata, wstrb
    localparam logic [2:0]  ST_FCS [5] = '{3'b001, 3'b000, 3'b000, 3'b001, 3'b010};
    localparam logic [31:0] ST_ADR [5] = '{32'h202, 32'h1, 32'h3, 32'h0, 32'h8};
    localparam logic [31:0] ST_RS2 [5] = '{32'hABCD_5678, 32'h1234_56EF, 32'h0000_00AB,
                                           32'h0000_BEEF, 32'hCAFE_F00D};
    localparam logic [31:0] ST_BA  [5] = '{32'h200, 32'h0, 32'h0, 32'h0, 32'h8};
    localparam logic [31:0] ST_WD  [5] = '{32'h5678_5678, 32'hEFEF_EFEF, 32'hABAB_ABAB,
                                           32'hBEEF_BEEF, 32'hCAFE_F00D};
    localparam logic [3:0]  ST_WS  [5] = '{4'b1100, 4'b0010, 4'b1000, 4'b0011, 4'b1111};
    // decode faults: iop, fcs, addr
    localparam logic        FT_IOP [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                            1'b1, 1'b1, 1'b1, 1'b1};
    localparam logic [2:0]  FT_FCS [11] = '{3'b010, 3'b001, 3'b101, 3'b010, 3'b011, 3'b110,
                                            3'b111, 3'b100, 3'b011, 3'b001, 3'b010};
    localparam logic [31:0] FT_ADR [11] = '{32'h101, 32'h1, 32'h3, 32'h102, 32'h0, 32'h0,
                                            32'h0, 32'h0, 32'h0, 32'h201, 32'h2};

    function automatic logic [15:0] ctl(input logic mem, input logic iop, input logic [2:0] fcs,
                                        input logic [10:0] tag);
        return {tag, fcs, iop, mem};
    endfunction

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic issue(input logic [15:0] c, input logic [31:0] a, input logic [31:0] d);
        i_control_signal = c;
        i_rd_output = a;
        i_rs2 = d;
        i_ex_done = 1'b1;
        step();
        i_ex_done = 1'b0;
    endtask

    task automatic test_reset();
        i_reset_n = 1'b0;
        #1;
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", o_ready); end
        checks++; if (o_mem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", o_mem_req); end
        checks++; if (o_wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid got %b want 0", o_wb_valid); end
        checks++; if (o_fault !== 1'b0) begin errors++; $display("FAIL reset_fault got %b want 0", o_fault); end
        checks++; if (o_wb_data !== 32'h0) begin errors++; $display("FAIL reset_wb_data got %h want 0", o_wb_data); end
        checks++; if ({o_mem_we, o_mem_wstrb} !== 5'h0) begin errors++; $display("FAIL reset_we_wstrb got %b want 0", {o_mem_we, o_mem_wstrb}); end
        checks++; if ({o_mem_addr, o_mem_wdata} !== 64'h0) begin errors++; $display("FAIL reset_addr_wdata got %h want 0", {o_mem_addr, o_mem_wdata}); end
        checks++; if (o_control_signal !== 16'h0) begin errors++; $display("FAIL reset_ctl got %h want 0", o_control_signal); end
        step();
        step();
        i_reset_n = 1'b1;
        step();
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready got %b want 1", o_ready); end
    endtask

    task automatic test_alu();
        issue(ctl(1'b0, 1'b0, 3'b000, 11'h5A), 32'h0000_1234, 32'hFFFF_FFFF);
        checks++; if (o_wb_valid !== 1'b1) begin errors++; $display("FAIL alu_wb_valid got %b want 1", o_wb_valid); end
        checks++; if (o_wb_data !== 32'h1234) begin errors++; $display("FAIL alu_wb_data got %h want 00001234", o_wb_data); end
        checks++; if (o_mem_req !== 1'b0) begin errors++; $display("FAIL alu_mem_req got %b want 0", o_mem_req); end
        checks++; if (o_fault !== 1'b0) begin errors++; $display("FAIL alu_fault got %b want 0", o_fault); end
        checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL alu_ready got %b want 0", o_ready); end
        checks++; if (o_control_signal !== {11'h5A, 5'b00000}) begin errors++; $display("FAIL alu_ctl got %h want %h", o_control_signal, {11'h5A, 5'b00000}); end
        step();
        checks++; if ({o_wb_valid, o_ready} !== 2'b01) begin errors++; $display("FAIL alu_return got %b want 01", {o_wb_valid, o_ready}); end
    endtask

    task automatic test_lb_late_ack();
        i_mem_rdata = 32'h80FF_0000;
        issue(ctl(1'b1, 1'b0, 3'b000, 11'h3), 32'h103, 32'h0);
        for (int i = 0; i < 3; i++) begin
            checks++; if ({o_mem_req, o_wb_valid} !== 2'b10) begin errors++; $display("FAIL lb_wait%0d req/valid got %b want 10", i, {o_mem_req, o_wb_valid}); end
            checks++; if ({o_mem_addr, o_mem_wstrb, o_mem_we} !== {32'h100, 4'b0000, 1'b0}) begin errors++; $display("FAIL lb_wait%0d addr/wstrb/we got %h want %h", i, {o_mem_addr, o_mem_wstrb, o_mem_we}, {32'h100, 4'b0000, 1'b0}); end
            step();
        end
        i_mem_ack = 1'b1;
        step();
        i_mem_ack = 1'b0;
        checks++; if ({o_wb_valid, o_mem_req, o_fault} !== 3'b100) begin errors++; $display("FAIL lb_done valid/req/fault got %b want 100", {o_wb_valid, o_mem_req, o_fault}); end
        checks++; if (o_wb_data !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_wb_data got %h want ffffff80", o_wb_data); end
        step();
    endtask

    task automatic test_loads();
        for (int i = 0; i < 6; i++) begin
            i_mem_rdata = LD_RD[i];
            issue(ctl(1'b1, 1'b0, LD_FCS[i], 11'(i)), LD_ADR[i], 32'h0);
            checks++; if ({o_mem_req, o_mem_we, o_mem_wstrb} !== 6'b100000) begin errors++; $display("FAIL load%0d req/we/wstrb got %b want 100000", i, {o_mem_req, o_mem_we, o_mem_wstrb}); end
            checks++; if (o_mem_addr !== LD_BA[i]) begin errors++; $display("FAIL load%0d addr got %h want %h", i, o_mem_addr, LD_BA[i]); end
            i_mem_ack = 1'b1;
            step();
            i_mem_ack = 1'b0;
            checks++; if ({o_wb_valid, o_fault} !== 2'b10) begin errors++; $display("FAIL load%0d valid/fault got %b want 10", i, {o_wb_valid, o_fault}); end
            checks++; if (o_wb_data !== LD_EXP[i]) begin errors++; $display("FAIL load%0d wb_data got %h want %h", i, o_wb_data, LD_EXP[i]); end
            step();
        end
    endtask

    task automatic test_stores();
        for (int i = 0; i < 5; i++) begin
            issue(ctl(1'b1, 1'b1, ST_FCS[i], 11'(i)), ST_ADR[i], ST_RS2[i]);
            checks++; if ({o_mem_req, o_mem_we} !== 2'b11) begin errors++; $display("FAIL store%0d req/we got %b want 11", i, {o_mem_req, o_mem_we}); end
            checks++; if (o_mem_addr !== ST_BA[i]) begin errors++; $display("FAIL store%0d addr got %h want %h", i, o_mem_addr, ST_BA[i]); end
            checks++; if (o_mem_wdata !== ST_WD[i]) begin errors++; $display("FAIL store%0d wdata got %h want %h", i, o_mem_wdata, ST_WD[i]); end
            checks++; if (o_mem_wstrb !== ST_WS[i]) begin errors++; $display("FAIL store%0d wstrb got %b want %b", i, o_mem_wstrb, ST_WS[i]); end
            i_mem_ack = 1'b1;
            step();
            i_mem_ack = 1'b0;
            checks++; if ({o_wb_valid, o_fault, o_mem_req} !== 3'b100) begin errors++; $display("FAIL store%0d valid/fault/req got %b want 100", i, {o_wb_valid, o_fault, o_mem_req}); end
            checks++; if (o_wb_data !== 32'h0) begin errors++; $display("FAIL store%0d wb_data got %h want 0", i, o_wb_data); end
            step();
        end
    endtask

    task automatic test_faults();
        for (int i = 0; i < 11; i++) begin
            issue(ctl(1'b1, FT_IOP[i], FT_FCS[i], 11'h0), FT_ADR[i], 32'h1111_1111);
            checks++; if ({o_wb_valid, o_fault, o_mem_req} !== 3'b110) begin errors++; $display("FAIL fault%0d valid/fault/req got %b want 110", i, {o_wb_valid, o_fault, o_mem_req}); end
            checks++; if (o_wb_data !== 32'h0) begin errors++; $display("FAIL fault%0d wb_data got %h want 0", i, o_wb_data); end
            step();
            checks++; if ({o_ready, o_mem_req} !== 2'b10) begin errors++; $display("FAIL fault%0d ready/req got %b want 10", i, {o_ready, o_mem_req}); end
        end
    endtask

    task automatic test_reset_mid_bus();
        issue(ctl(1'b1, 1'b0, 3'b010, 11'h7), 32'h40, 32'h0);
        checks++; if (o_mem_req !== 1'b1) begin errors++; $display("FAIL rst_bus_req_before got %b want 1", o_mem_req); end
        #2;
        i_reset_n = 1'b0;
        #1;
        checks++; if ({o_mem_req, o_ready, o_wb_valid} !== 3'b010) begin errors++; $display("FAIL rst_bus_async got %b want 010", {o_mem_req, o_ready, o_wb_valid}); end
        i_reset_n = 1'b1;
        i_mem_ack = 1'b1;
        i_mem_rdata = 32'h7777_7777;
        step();
        step();
        i_mem_ack = 1'b0;
        checks++; if ({o_mem_req, o_ready, o_wb_valid} !== 3'b010) begin errors++; $display("FAIL rst_stray_ack got %b want 010", {o_mem_req, o_ready, o_wb_valid}); end
    endtask

    task automatic test_back_to_back();
        issue(ctl(1'b0, 1'b0, 3'b000, 11'h1), 32'h11, 32'h0);
        i_control_signal = ctl(1'b0, 1'b0, 3'b000, 11'h2);
        i_rd_output = 32'h22;
        i_ex_done = 1'b1;
        step();
        checks++; if ({o_wb_valid, o_ready} !== 2'b01) begin errors++; $display("FAIL b2b_gap got %b want 01", {o_wb_valid, o_ready}); end
        step();
        i_ex_done = 1'b0;
        checks++; if ({o_wb_valid, o_wb_data} !== {1'b1, 32'h22}) begin errors++; $display("FAIL b2b_second got %h want 100000022", {o_wb_valid, o_wb_data}); end
        step();
        issue(ctl(1'b1, 1'b0, 3'b010, 11'h3), 32'h10, 32'h0);
        i_control_signal = ctl(1'b0, 1'b0, 3'b000, 11'h4);
        i_rd_output = 32'h99;
        i_ex_done = 1'b1;
        step();
        i_ex_done = 1'b0;
        checks++; if ({o_mem_req, o_wb_valid} !== 2'b10) begin errors++; $display("FAIL busy_ex_done got %b want 10", {o_mem_req, o_wb_valid}); end
        i_mem_rdata = 32'h0000_0055;
        i_mem_ack = 1'b1;
        step();
        i_mem_ack = 1'b0;
        checks++; if ({o_wb_valid, o_wb_data} !== {1'b1, 32'h55}) begin errors++; $display("FAIL busy_wb got %h want 100000055", {o_wb_valid, o_wb_data}); end
        step();
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL busy_return got %b want 1", o_ready); end
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout();
        issue(ctl(1'b1, 1'b0, 3'b010, 11'h0), 32'h20, 32'h0);
        for (int i = 0; i < 4; i++) begin
            checks++; if ({o_mem_req, o_wb_valid} !== 2'b10) begin errors++; $display("FAIL tmo_wait%0d got %b want 10", i, {o_mem_req, o_wb_valid}); end
            step();
        end
        checks++; if ({o_mem_req, o_wb_valid, o_fault} !== 3'b011) begin errors++; $display("FAIL tmo_done got %b want 011", {o_mem_req, o_wb_valid, o_fault}); end
        checks++; if (o_wb_data !== 32'h0) begin errors++; $display("FAIL tmo_wb_data got %h want 0", o_wb_data); end
        step();
    endtask
`endif

    initial begin
        i_ex_done = 1'b0;
        i_control_signal = '0;
        i_rd_output = '0;
        i_rs2 = '0;
        i_mem_ack = 1'b0;
        i_mem_rdata = '0;
        test_reset();
        test_alu();
        test_lb_late_ack();
        test_loads();
        test_stores();
        test_faults();
        test_reset_mid_bus();
        test_back_to_back();
`ifdef MEM_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
